// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_tick_gen.sv
// Prescaler: emits one tick every (psc+1) enabled clocks and owns the prescale counter.
module tick_gen #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

    logic [PSC_W-1:0] psc_cnt_q;
    logic [PSC_W-1:0] psc_cnt_d;

    assign tick = run && (psc_cnt_q == psc);

    // clr has priority so a restart always begins a fresh prescale interval.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr) begin
            psc_cnt_d = '0;
        end else if (run) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Runtime-programmable timer: prescaled period counter, one-shot or periodic,
// with stop/start/pause control, a done pulse per expiry and a sticky irq.
module prog_timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    input  logic             irq_clr,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    timer_state_e     state_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] count_q;
    logic [PSC_W-1:0] psc_q;
    logic             mode_q;
    logic             done_q;
    logic             irq_q;
    logic             tick;
    logic             run_en;
    logic             psc_clr;

    // Counting follows the pause level, not the state: the RUN->HOLD edge does not
    // count and the HOLD->RUN edge does, so a pause costs exactly its own length.
    assign run_en  = (state_q != IDLE) && !pause;
    assign psc_clr = start || stop || (state_q == IDLE);

    tick_gen #(.PSC_W(PSC_W)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_en),
        .clr   (psc_clr),
        .psc   (psc_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            count_q <= '0;
            psc_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            irq_q  <= done_q | (irq_q & ~irq_clr);
            if (stop) begin
                state_q <= IDLE;
                count_q <= '0;
            end else if (start) begin
                state_q <= RUN;
                per_q   <= (period == '0) ? ONE : period;
                psc_q   <= prescale;
                mode_q  <= mode;
                count_q <= '0;
            end else if (state_q != IDLE) begin
                if (pause) begin
                    state_q <= HOLD;
                end else begin
                    state_q <= RUN;
                    if (tick) begin
                        if (count_q == per_q - ONE) begin
                            done_q  <= 1'b1;
                            count_q <= '0;
                            if (mode_q == MODE_ONESHOT) state_q <= IDLE;
                        end else begin
                            count_q <= count_q + ONE;
                        end
                    end
                end
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign irq   = irq_q;
    assign count = count_q;

endmodule
